jtag_debug_cmd_sysclk_queue: RTL and testbench

- Parametrised system-clock-side command receiver for the Nios II JTAG debug module; successor to the fixed 2-bit-IR, single-shot sysclk decoder.
- Synchronises the virtual-JTAG update strobes into clk, captures {ir_in, sr} into a small command FIFO, and pops with a valid/ready handshake.
- On each pop, emits one-hot take_action/take_no_action pulses per IR opcode, so back-to-back JTAG updates are no longer lost while the CPU is busy.

---
 rtl/jtag_debug_cmd_sysclk_queue.sv | 225 ++++++++++++++++++++++
 tb/tb_jtag_debug_cmd_sysclk_queue.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_cmd_sysclk_queue.sv
// jtag_debug_cmd_sysclk_queue
// System-clock side command receiver for the JTAG debug module. Virtual-JTAG
// update strobes are synchronised into clk. Each update-DR edge captures
// {ir_in, sr} into a small FIFO. The FIFO is drained with a valid/ready
// handshake, and every pop emits a one-hot take_action / take_no_action pulse
// for the popped opcode.
// Optional build macro: JTAG_CMD_WATCHDOG_EN. It adds a head-of-queue watchdog
// and the timeout_sticky output.
module jtag_debug_cmd_sysclk_queue #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vs_udr,
  input  logic                        vs_uir,
  input  logic [IR_W-1:0]             ir_in,
  input  logic [SR_W-1:0]             sr,
  input  logic                        cmd_ready,
  input  logic                        overflow_clr,
  output logic                        cmd_valid,
  output logic [SR_W-1:0]             jdo,
  output logic [IR_W-1:0]             cmd_ir,
  output logic [(2**IR_W)-1:0]        take_action,
  output logic [(2**IR_W)-1:0]        take_no_action,
  output logic                        uir_pulse,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow_sticky
`ifdef JTAG_CMD_WATCHDOG_EN
  ,
  output logic                        timeout_sticky
`endif
);

  localparam int NCH   = 2**IR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IR_W + SR_W;

  // Reject parameter values that the queue, synchronisers or watchdog cannot support.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Strobe synchronisers with rising-edge detect.
  // 'fill' marks when the synchroniser outputs hold real input samples instead
  // of reset zeros. An edge is armed only after a genuine low has been seen.
  // A strobe that is still high when reset is released is therefore ignored
  // until it goes low and then rises again.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] fill;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_dly;
  logic                   uir_dly;
  logic                   udr_arm;
  logic                   uir_arm;
  logic                   udr_edge;
  logic                   udr_last;
  logic                   uir_last;

  assign udr_last = udr_sync[SYNC_STAGES-1];
  assign uir_last = uir_sync[SYNC_STAGES-1];

  // Synchronise both strobes and register their one-cycle rising-edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill      <= {SYNC_STAGES{1'b0}};
      udr_sync  <= {SYNC_STAGES{1'b0}};
      uir_sync  <= {SYNC_STAGES{1'b0}};
      udr_dly   <= 1'b0;
      uir_dly   <= 1'b0;
      udr_arm   <= 1'b0;
      uir_arm   <= 1'b0;
      udr_edge  <= 1'b0;
      uir_pulse <= 1'b0;
    end else begin
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_dly   <= udr_last;
      uir_dly   <= uir_last;
      udr_arm   <= udr_arm | (fill[SYNC_STAGES-1] & ~udr_last);
      uir_arm   <= uir_arm | (fill[SYNC_STAGES-1] & ~uir_last);
      udr_edge  <= udr_last & ~udr_dly & udr_arm;
      uir_pulse <= uir_last & ~uir_dly & uir_arm;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_next;
  logic [ENT_W-1:0] push_data;
  logic [ENT_W-1:0] head_next;
  logic             push;
  logic             pop;
  logic             full;
  logic             do_write;
  logic             ovf_set;
  logic             timeout;

  assign push_data = {ir_in, sr};

`ifdef JTAG_CMD_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  assign timeout = cmd_valid & ~cmd_ready & (wd_cnt == WD_W'(TIMEOUT_CYC));

  // Count the cycles the head waits unaccepted, and latch the timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt         <= {WD_W{1'b0}};
      timeout_sticky <= 1'b0;
    end else begin
      if (!cmd_valid || pop) begin
        wd_cnt <= {WD_W{1'b0}};
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1'b1);
      end
      if (timeout) begin
        timeout_sticky <= 1'b1;
      end else if (overflow_clr) begin
        timeout_sticky <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Decide push/pop/drop for this cycle and work out the next head entry.
  // A freshly written entry is not yet in mem. When it becomes the head, it
  // is forwarded straight from the capture inputs.
  always_comb begin
    push     = udr_edge;
    full     = (fifo_count == CNT_W'(FIFO_DEPTH));
    pop      = cmd_valid & (cmd_ready | timeout);
    do_write = push & (~full | pop);
    ovf_set  = push & full & ~pop;
    case ({do_write, pop})
      2'b10:   count_next = fifo_count + CNT_W'(1'b1);
      2'b01:   count_next = fifo_count - CNT_W'(1'b1);
      default: count_next = fifo_count;
    endcase
    if (pop) begin
      rd_next = rd_ptr + PTR_W'(1'b1);
    end else begin
      rd_next = rd_ptr;
    end
    if (count_next == {CNT_W{1'b0}}) begin
      head_next = {cmd_ir, jdo};
    end else if (do_write && ((fifo_count == {CNT_W{1'b0}}) ||
                              (pop && (fifo_count == CNT_W'(1'b1))))) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // Storage array; it is discarded logically by the pointer/count reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, registered head outputs and the overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= {PTR_W{1'b0}};
      rd_ptr          <= {PTR_W{1'b0}};
      fifo_count      <= {CNT_W{1'b0}};
      cmd_valid       <= 1'b0;
      jdo             <= {SR_W{1'b0}};
      cmd_ir          <= {IR_W{1'b0}};
      overflow_sticky <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1'b1);
      end
      rd_ptr          <= rd_next;
      fifo_count      <= count_next;
      cmd_valid       <= (count_next != {CNT_W{1'b0}});
      {cmd_ir, jdo}   <= head_next;
      if (ovf_set) begin
        overflow_sticky <= 1'b1;
      end else if (overflow_clr) begin
        overflow_sticky <= 1'b0;
      end
    end
  end

  // One-hot pop pulses decoded from the head opcode and its action bit.
  always_comb begin
    take_action    = {NCH{1'b0}};
    take_no_action = {NCH{1'b0}};
    if (pop) begin
      if (jdo[SR_W-1] && !timeout) begin
        take_action[cmd_ir] = 1'b1;
      end else begin
        take_no_action[cmd_ir] = 1'b1;
      end
    end else begin
      take_action    = {NCH{1'b0}};
      take_no_action = {NCH{1'b0}};
    end
  end

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk_queue.sv
// Self-checking bench for jtag_debug_cmd_sysclk_queue (default build).
`timescale 1ns/1ps
module tb_jtag_debug_cmd_sysclk_queue;
  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            vs_udr = 1'b0;
  logic            vs_uir = 1'b0;
  logic [IR_W-1:0] ir_in = 2'b00;
  logic [SR_W-1:0] sr = 38'h0;
  logic            cmd_ready = 1'b0;
  logic            overflow_clr = 1'b0;
  logic            cmd_valid;
  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] cmd_ir;
  logic [3:0]      take_action;
  logic [3:0]      take_no_action;
  logic            uir_pulse;
  logic [2:0]      fifo_count;
  logic            overflow_sticky;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  jtag_debug_cmd_sysclk_queue #(
    .SR_W(SR_W), .IR_W(IR_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYC(255)
  ) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overflow_clr(overflow_clr),
    .cmd_valid(cmd_valid), .jdo(jdo), .cmd_ir(cmd_ir),
    .take_action(take_action), .take_no_action(take_no_action),
    .uir_pulse(uir_pulse), .fifo_count(fifo_count), .overflow_sticky(overflow_sticky)
  );

  function automatic logic [37:0] rand_sr();
    return {6'($urandom_range(63, 0)), 32'($urandom)};
  endfunction

  // One update-DR strobe: high 3 cycles, low 4 cycles; the push lands inside.
  task automatic strobe(input logic [1:0] ir, input logic [37:0] d);
    @(negedge clk);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL reset_queue: valid=%b count=%0d want 0 0", cmd_valid, fifo_count);
    end
    total++;
    if (jdo !== 38'h0 || cmd_ir !== 2'b00) begin
      bad++; $display("FAIL reset_head: jdo=%h ir=%b want 0", jdo, cmd_ir);
    end
    total++;
    if (take_action !== 4'h0 || take_no_action !== 4'h0 || uir_pulse !== 1'b0 || overflow_sticky !== 1'b0) begin
      bad++; $display("FAIL reset_flags: ta=%b tn=%b uir=%b ovf=%b want 0", take_action, take_no_action, uir_pulse, overflow_sticky);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || uir_pulse !== 1'b0) begin
      bad++; $display("FAIL reset_idle: valid=%b count=%0d uir=%b want 0", cmd_valid, fifo_count, uir_pulse);
    end
  endtask

  task automatic test_single_push();
    logic exp_v;
    @(negedge clk);
    ir_in = 2'b01; sr = 38'h20_0000_0005; vs_udr = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      exp_v = (e == 4);
      total++;
      if (cmd_valid !== exp_v) begin
        bad++; $display("FAIL valid_latency edge %0d: got %b want %b", e, cmd_valid, exp_v);
      end
    end
    repeat (6) @(negedge clk);
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL single_push_count: got %0d want 1", fifo_count);
    end
    total++;
    if (jdo !== 38'h20_0000_0005 || cmd_ir !== 2'b01) begin
      bad++; $display("FAIL single_push_head: got %b/%h want 01/2000000005", cmd_ir, jdo);
    end
  endtask

  task automatic test_pop();
    @(negedge clk);
    cmd_ready = 1'b1;
    #1;
    total++;
    if (take_action !== 4'b0010 || take_no_action !== 4'b0000) begin
      bad++; $display("FAIL pop_pulse: ta=%b tn=%b want 0010 0000", take_action, take_no_action);
    end
    total++;
    if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL pop_count_before: got %0d want 1", fifo_count);
    end
    @(negedge clk);
    cmd_ready = 1'b0;
    #1;
    total++;
    if (fifo_count !== 3'd0 || cmd_valid !== 1'b0) begin
      bad++; $display("FAIL pop_count_after: count=%0d valid=%b want 0 0", fifo_count, cmd_valid);
    end
    total++;
    if (take_action !== 4'h0 || take_no_action !== 4'h0 || jdo !== 38'h20_0000_0005) begin
      bad++; $display("FAIL pop_after_hold: ta=%b tn=%b jdo=%h want 0 0 2000000005", take_action, take_no_action, jdo);
    end
  endtask

  task automatic test_overflow();
    logic [1:0]  ir;
    logic [37:0] d;
    logic [39:0] e;
    logic [3:0]  ea, en;
    logic        ovf;
    ovf = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      ir = 2'($urandom_range(3, 0));
      d = rand_sr();
      d[37] = i[0];
      strobe(ir, d);
      if (exp_q.size() < DEPTH) exp_q.push_back({ir, d});
      else ovf = 1'b1;
    end
    #1;
    total++;
    if (fifo_count !== 3'd4 || overflow_sticky !== ovf) begin
      bad++; $display("FAIL overflow_state: count=%0d ovf=%b want 4 %b", fifo_count, overflow_sticky, ovf);
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cmd_ready = 1'b1;
      #1;
      e = exp_q.pop_front();
      ea = 4'h0; en = 4'h0;
      if (e[37]) ea[e[39:38]] = 1'b1;
      else en[e[39:38]] = 1'b1;
      total++;
      if ({cmd_ir, jdo} !== e) begin
        bad++; $display("FAIL overflow_order: got %h want %h", {cmd_ir, jdo}, e);
      end
      total++;
      if (take_action !== ea || take_no_action !== en) begin
        bad++; $display("FAIL overflow_pulse: ta=%b tn=%b want %b %b", take_action, take_no_action, ea, en);
      end
    end
    @(negedge clk);
    cmd_ready = 1'b0;
    #1;
    total++;
    if (fifo_count !== 3'd0 || cmd_valid !== 1'b0) begin
      bad++; $display("FAIL overflow_drained: count=%0d valid=%b want 0 0", fifo_count, cmd_valid);
    end
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    #1;
    total++;
    if (overflow_sticky !== 1'b0) begin
      bad++; $display("FAIL overflow_clear: got %b want 0", overflow_sticky);
    end
  endtask

  task automatic test_push_pop_full();
    logic [1:0]  ir;
    logic [37:0] d;
    logic [39:0] e;
    logic [3:0]  ea, en;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      ir = 2'($urandom_range(3, 0));
      d = rand_sr();
      strobe(ir, d);
      exp_q.push_back({ir, d});
    end
    ir = 2'($urandom_range(3, 0));
    d = rand_sr();
    @(negedge clk);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    cmd_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    ea = 4'h0; en = 4'h0;
    if (e[37]) ea[e[39:38]] = 1'b1;
    else en[e[39:38]] = 1'b1;
    total++;
    if (take_action !== ea || take_no_action !== en || {cmd_ir, jdo} !== e) begin
      bad++; $display("FAIL full_pop_pulse: ta=%b tn=%b head=%h want %b %b %h", take_action, take_no_action, {cmd_ir, jdo}, ea, en, e);
    end
    @(negedge clk);
    cmd_ready = 1'b0;
    vs_udr = 1'b0;
    exp_q.push_back({ir, d});
    #1;
    total++;
    if (fifo_count !== 3'd4 || overflow_sticky !== 1'b0) begin
      bad++; $display("FAIL full_push_pop: count=%0d ovf=%b want 4 0", fifo_count, overflow_sticky);
    end
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cmd_ready = 1'b1;
      #1;
      e = exp_q.pop_front();
      total++;
      if ({cmd_ir, jdo} !== e) begin
        bad++; $display("FAIL full_order: got %h want %h", {cmd_ir, jdo}, e);
      end
    end
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic test_uir();
    logic [37:0] d;
    int hi;
    d = rand_sr();
    strobe(2'b11, d);
    hi = 0;
    @(negedge clk);
    vs_uir = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 5) vs_uir = 1'b0;
      #1;
      if (uir_pulse === 1'b1) hi++;
    end
    total++;
    if (hi !== 1) begin
      bad++; $display("FAIL uir_pulse_width: got %0d cycles want 1", hi);
    end
    total++;
    if (fifo_count !== 3'd1 || {cmd_ir, jdo} !== {2'b11, d}) begin
      bad++; $display("FAIL uir_fifo: count=%0d head=%h want 1 %h", fifo_count, {cmd_ir, jdo}, {2'b11, d});
    end
  endtask

  task automatic test_reset_mid();
    logic [37:0] d;
    strobe(2'b00, rand_sr());
    strobe(2'b01, rand_sr());
    #1;
    total++;
    if (fifo_count !== 3'd3) begin
      bad++; $display("FAIL mid_prefill: got %0d want 3", fifo_count);
    end
    @(negedge clk);
    ir_in = 2'b10; sr = rand_sr(); vs_udr = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL mid_async_reset: valid=%b count=%0d want 0 0", cmd_valid, fifo_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (8) @(negedge clk);
    #1;
    total++;
    if (fifo_count !== 3'd0 || cmd_valid !== 1'b0) begin
      bad++; $display("FAIL mid_held_strobe: count=%0d valid=%b want 0 0", fifo_count, cmd_valid);
    end
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    d = rand_sr();
    strobe(2'b10, d);
    #1;
    total++;
    if (fifo_count !== 3'd1 || {cmd_ir, jdo} !== {2'b10, d}) begin
      bad++; $display("FAIL mid_rearm: count=%0d head=%h want 1 %h", fifo_count, {cmd_ir, jdo}, {2'b10, d});
    end
  endtask

  // Cycle-level random traffic against a queue model: a push lands on the
  // fourth clk edge counted from the strobe rise, and pops happen when the
  // model queue is non-empty and cmd_ready is high.
  task automatic test_random_traffic();
    logic [39:0] q[$];
    logic        pv [3];
    logic [39:0] pd [3];
    logic        ovf, rise_now, do_pop, do_push, ovf_set;
    logic [3:0]  ea, en;
    int          hold, rate;
    @(negedge clk);
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    ovf = 1'b0; hold = 0;
    for (int k = 0; k < 3; k++) begin pv[k] = 1'b0; pd[k] = 40'h0; end
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      rise_now = 1'b0;
      if (hold > 0) hold--;
      else if (vs_udr) begin
        vs_udr = 1'b0; hold = $urandom_range(4, 2);
      end else begin
        vs_udr = 1'b1; ir_in = 2'($urandom_range(3, 0)); sr = rand_sr();
        rise_now = 1'b1; hold = $urandom_range(3, 1);
      end
      rate = (cyc < 250) ? 15 : 60;
      cmd_ready = ($urandom_range(99, 0) < rate);
      overflow_clr = ($urandom_range(31, 0) == 0);
      #1;
      total++;
      if (cmd_valid !== (q.size() != 0) || fifo_count !== 3'(q.size())) begin
        bad++; $display("FAIL rnd_count cyc %0d: valid=%b count=%0d want %0d", cyc, cmd_valid, fifo_count, q.size());
      end
      total++;
      if (overflow_sticky !== ovf) begin
        bad++; $display("FAIL rnd_overflow cyc %0d: got %b want %b", cyc, overflow_sticky, ovf);
      end
      ea = 4'h0; en = 4'h0;
      if (q.size() != 0) begin
        total++;
        if ({cmd_ir, jdo} !== q[0]) begin
          bad++; $display("FAIL rnd_head cyc %0d: got %h want %h", cyc, {cmd_ir, jdo}, q[0]);
        end
        if (cmd_ready) begin
          if (q[0][37]) ea[q[0][39:38]] = 1'b1;
          else en[q[0][39:38]] = 1'b1;
        end
      end
      total++;
      if (take_action !== ea || take_no_action !== en) begin
        bad++; $display("FAIL rnd_pulse cyc %0d: ta=%b tn=%b want %b %b", cyc, take_action, take_no_action, ea, en);
      end
      // model update for the coming clk edge
      do_pop  = (q.size() != 0) && cmd_ready;
      do_push = pv[2];
      ovf_set = do_push && (q.size() == DEPTH) && !do_pop;
      if (do_pop) void'(q.pop_front());
      if (do_push && !ovf_set) q.push_back(pd[2]);
      if (ovf_set) ovf = 1'b1;
      else if (overflow_clr) ovf = 1'b0;
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = rise_now; pd[0] = {ir_in, sr};
    end
    @(negedge clk);
    cmd_ready = 1'b0; overflow_clr = 1'b0; vs_udr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_pop();
    test_overflow();
    test_push_pop_full();
    test_uir();
    test_reset_mid();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
